// File: rtl/alu_ctrl_pkg.sv
// Shared widths, opcodes, instruction field positions and FSM encoding for the ALU issue controller.
package alu_ctrl_pkg;
    localparam int DATA_W  = 8;
    localparam int NREGS   = 4;
    localparam int RA_W    = $clog2(NREGS);
    localparam int OP_W    = 3;
    localparam int INSTR_W = 8;

    localparam logic [OP_W-1:0] OP_SLT  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_SLL  = 3'b010;
    localparam logic [OP_W-1:0] OP_SRL  = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b100;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b101;
    localparam logic [OP_W-1:0] OP_PASS = 3'b110;
    localparam logic [OP_W-1:0] OP_CMP  = 3'b111;

    // Instruction word layout; bit 0 is reserved.
    localparam int OP_MSB = 7;
    localparam int OP_LSB = 5;
    localparam int RS_MSB = 4;
    localparam int RS_LSB = 3;
    localparam int RT_MSB = 2;
    localparam int RT_LSB = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RETIRE = 2'd2
    } state_e;

    // Compare ops only set flags; their result is not written back.
    function automatic logic is_compare(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_CMP);
    endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, preload, debug-read and ALU-side signals of the issue controller.
interface alu_issue_ctrl_if;
    import alu_ctrl_pkg::*;

    logic               instr_valid_i;
    logic [INSTR_W-1:0] instr_i;
    logic               instr_ready_o;
    logic               wr_en_i;
    logic [RA_W-1:0]    wr_addr_i;
    logic [DATA_W-1:0]  wr_data_i;
    logic [RA_W-1:0]    rd_addr_i;
    logic [DATA_W-1:0]  rd_data_o;
    logic [DATA_W-1:0]  alu_rs_o;
    logic [DATA_W-1:0]  alu_rt_o;
    logic [OP_W-1:0]    alu_opcode_o;
    logic [DATA_W-1:0]  alu_result_i;
    logic               alu_zero_i;
    logic [DATA_W-1:0]  result_o;
    logic               zero_flag_o;
    logic               done_o;
    logic               busy_o;

    modport master (
        output instr_valid_i, instr_i, wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
               alu_result_i, alu_zero_i,
        input  instr_ready_o, rd_data_o, alu_rs_o, alu_rt_o, alu_opcode_o,
               result_o, zero_flag_o, done_o, busy_o
    );

    modport slave (
        input  instr_valid_i, instr_i, wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
               alu_result_i, alu_zero_i,
        output instr_ready_o, rd_data_o, alu_rs_o, alu_rt_o, alu_opcode_o,
               result_o, zero_flag_o, done_o, busy_o
    );
endinterface

// File: rtl/alu_ctrl_regfile.sv
// Small register file: one write port, three combinational read ports (rs, rt, debug).
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   ra_rs,
    input  logic [RA_W-1:0]   ra_rt,
    input  logic [RA_W-1:0]   ra_dbg,
    output logic [DATA_W-1:0] rd_rs,
    output logic [DATA_W-1:0] rd_rt,
    output logic [DATA_W-1:0] rd_dbg
);
    logic [NREGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     regs        <= '0;
        else if (we) regs[waddr] <= wdata;
    end

    assign rd_rs  = regs[ra_rs];
    assign rd_rt  = regs[ra_rt];
    assign rd_dbg = regs[ra_dbg];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts an instruction, presents operands to the external ALU,
// captures its result one cycle later and writes it back to the destination register.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    alu_issue_ctrl_if.slave bus
);
    state_e            state;
    logic [DATA_W-1:0] alu_rs_q, alu_rt_q, result_q;
    logic [OP_W-1:0]   alu_opcode_q;
    logic [RA_W-1:0]   dest_q;
    logic              zero_q, done_q;

    logic [OP_W-1:0]   op;
    logic [RA_W-1:0]   rs_a, rt_a;
    logic [DATA_W-1:0] rd_rs, rd_rt;
    logic              accept;
    logic              we;
    logic [RA_W-1:0]   waddr;
    logic [DATA_W-1:0] wdata;
    logic              unused_instr_rsvd;

    assign op                = bus.instr_i[OP_MSB:OP_LSB];
    assign rs_a              = bus.instr_i[RS_MSB:RS_LSB];
    assign rt_a              = bus.instr_i[RT_MSB:RT_LSB];
    assign unused_instr_rsvd = bus.instr_i[0];

    // A preload in IDLE takes the cycle; the instruction waits.
    assign bus.instr_ready_o = (state == S_IDLE) && !bus.wr_en_i;
    assign accept            = bus.instr_valid_i && bus.instr_ready_o;

    // Single write port shared by preload (IDLE only) and writeback (ISSUE).
    always_comb begin
        we    = 1'b0;
        waddr = bus.wr_addr_i;
        wdata = bus.wr_data_i;
        if (state == S_IDLE) begin
            we = bus.wr_en_i;
        end else if (state == S_ISSUE && !is_compare(alu_opcode_q)) begin
            we    = 1'b1;
            waddr = dest_q;
            wdata = bus.alu_result_i;
        end
    end

    alu_ctrl_regfile u_regfile (
        .clk    (clk_i),
        .rst    (rst_i),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .ra_rs  (rs_a),
        .ra_rt  (rt_a),
        .ra_dbg (bus.rd_addr_i),
        .rd_rs  (rd_rs),
        .rd_rt  (rd_rt),
        .rd_dbg (bus.rd_data_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            alu_rs_q     <= '0;
            alu_rt_q     <= '0;
            alu_opcode_q <= '0;
            dest_q       <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_rs_q     <= rd_rs;
                        alu_rt_q     <= rd_rt;
                        alu_opcode_q <= op;
                        dest_q       <= rs_a;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    result_q <= bus.alu_result_i;
                    zero_q   <= bus.alu_zero_i;
                    done_q   <= 1'b1;
                    state    <= S_RETIRE;
                end
                S_RETIRE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_rs_o     = alu_rs_q;
    assign bus.alu_rt_o     = alu_rt_q;
    assign bus.alu_opcode_o = alu_opcode_q;
    assign bus.result_o     = result_q;
    assign bus.zero_flag_o  = zero_q;
    assign bus.done_o       = done_q;
    assign bus.busy_o       = (state != S_IDLE);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench: vector table through a behavioural ALU, plus back-to-back, preload-collision and async-reset sequences.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_issue_ctrl_if ifc();

    alu_issue_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU, combinational from the controller's operand outputs.
    logic [DATA_W-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (ifc.alu_opcode_o)
            OP_SLT:                 alu_res = {7'b0, (ifc.alu_rs_o < ifc.alu_rt_o)};
            OP_OR:                  alu_res = ifc.alu_rs_o | ifc.alu_rt_o;
            OP_SLL:                 alu_res = ifc.alu_rs_o << ifc.alu_rt_o;
            OP_SRL:                 alu_res = ifc.alu_rs_o >> ifc.alu_rt_o;
            OP_SUB, OP_BEQ, OP_CMP: alu_res = ifc.alu_rs_o - ifc.alu_rt_o;
            OP_PASS:                alu_res = ifc.alu_rs_o;
            default:                alu_res = '0;
        endcase
        ifc.alu_result_i = alu_res;
        ifc.alu_zero_i   = (alu_res == '0);
    end

    typedef struct {
        logic [3:0][7:0] pre;
        logic [7:0]      instr;
        logic [7:0]      res;
        logic            zero;
        logic [3:0][7:0] post;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ifc.wr_en_i   = 1'b1;
        ifc.wr_addr_i = a;
        ifc.wr_data_i = d;
        @(negedge clk);
        ifc.wr_en_i   = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        ifc.rd_addr_i = a;
        #1;
        d = ifc.rd_data_o;
    endtask

    // Called at a negedge in IDLE; returns negedges from accept to done_o (-1 on timeout).
    task automatic issue_wait(input logic [7:0] instr, output int lat);
        ifc.instr_valid_i = 1'b1;
        ifc.instr_i       = instr;
        #1;
        chk("ready_before_accept", 32'(ifc.instr_ready_o), 32'd1);
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            ifc.instr_valid_i = 1'b0;
            if (ifc.done_o) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] rv;
        int         lat;
        int         d1, d2;
        bit         saw_done;

        // pre/post are {r3, r2, r1, r0}
        vecs[0] = '{pre: {8'h00, 8'h00, 8'h02, 8'h05}, instr: 8'h42, res: 8'h14, zero: 1'b0, post: {8'h00, 8'h00, 8'h02, 8'h14}};
        vecs[1] = '{pre: {8'hFA, 8'hFD, 8'h00, 8'h00}, instr: 8'h96, res: 8'h03, zero: 1'b0, post: {8'hFA, 8'h03, 8'h00, 8'h00}};
        vecs[2] = '{pre: {8'h00, 8'h01, 8'h01, 8'h00}, instr: 8'hAC, res: 8'h00, zero: 1'b1, post: {8'h00, 8'h01, 8'h01, 8'h00}};
        vecs[3] = '{pre: {8'h00, 8'h00, 8'h0C, 8'h30}, instr: 8'h22, res: 8'h3C, zero: 1'b0, post: {8'h00, 8'h00, 8'h0C, 8'h3C}};
        vecs[4] = '{pre: {8'h03, 8'h80, 8'h00, 8'h00}, instr: 8'h76, res: 8'h10, zero: 1'b0, post: {8'h03, 8'h10, 8'h00, 8'h00}};
        vecs[5] = '{pre: {8'h7E, 8'h00, 8'h00, 8'h00}, instr: 8'hFE, res: 8'h00, zero: 1'b1, post: {8'h7E, 8'h00, 8'h00, 8'h00}};
        vecs[6] = '{pre: {8'h00, 8'h00, 8'h09, 8'h04}, instr: 8'h02, res: 8'h01, zero: 1'b0, post: {8'h00, 8'h00, 8'h09, 8'h01}};
        vecs[7] = '{pre: {8'h00, 8'h00, 8'h02, 8'h01}, instr: 8'h83, res: 8'hFF, zero: 1'b0, post: {8'h00, 8'h00, 8'h02, 8'hFF}};

        rst               = 1'b1;
        ifc.instr_valid_i = 1'b0;
        ifc.instr_i       = '0;
        ifc.wr_en_i       = 1'b0;
        ifc.wr_addr_i     = '0;
        ifc.wr_data_i     = '0;
        ifc.rd_addr_i     = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy",   32'(ifc.busy_o),       32'd0);
        chk("rst_done",   32'(ifc.done_o),       32'd0);
        chk("rst_result", 32'(ifc.result_o),     32'd0);
        chk("rst_zero",   32'(ifc.zero_flag_o),  32'd0);
        chk("rst_alu_rs", 32'(ifc.alu_rs_o),     32'd0);
        chk("rst_alu_op", 32'(ifc.alu_opcode_o), 32'd0);
        chk("rst_rd",     32'(ifc.rd_data_o),    32'd0);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) preload(2'(k), vecs[i].pre[k]);
            issue_wait(vecs[i].instr, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_alu_rs", i), 32'(ifc.alu_rs_o), 32'(vecs[i].pre[vecs[i].instr[4:3]]));
            chk($sformatf("v%0d_result", i), 32'(ifc.result_o), 32'(vecs[i].res));
            chk($sformatf("v%0d_zero", i), 32'(ifc.zero_flag_o), 32'(vecs[i].zero));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(ifc.done_o), 32'd0);
            for (int k = 0; k < 4; k++) begin
                read_reg(2'(k), rv);
                chk($sformatf("v%0d_r%0d", i, k), 32'(rv), 32'(vecs[i].post[k]));
            end
        end

        // Back-to-back with instr_valid_i held: r0-r1=0, then r2|r3=FF
        preload(2'd0, 8'h01);
        preload(2'd1, 8'h01);
        preload(2'd2, 8'hF0);
        preload(2'd3, 8'h0F);
        @(negedge clk);
        ifc.instr_valid_i = 1'b1;
        ifc.instr_i       = 8'h82;
        d1 = -1;
        d2 = -1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) ifc.instr_i = 8'h36;
            if (n == 4) ifc.instr_valid_i = 1'b0;
            #1;
            if (n == 1 || n == 2 || n == 4 || n == 5)
                chk($sformatf("b2b_ready_n%0d", n), 32'(ifc.instr_ready_o), 32'd0);
            if (n == 3) begin
                chk("b2b_ready_idle", 32'(ifc.instr_ready_o), 32'd1);
                chk("b2b_res_a",      32'(ifc.result_o),      32'h00);
                chk("b2b_zero_a",     32'(ifc.zero_flag_o),   32'd1);
            end
            if (ifc.done_o) begin
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
            end
        end
        chk("b2b_done1", 32'(d1), 32'd2);
        chk("b2b_gap",   32'(d2 - d1), 32'd3);
        chk("b2b_res_b", 32'(ifc.result_o), 32'hFF);
        read_reg(2'd2, rv);
        chk("b2b_r2", 32'(rv), 32'hFF);

        // Preload collides with an instruction: write wins, instr uses the new value
        preload(2'd0, 8'h01);
        @(negedge clk);
        ifc.wr_en_i       = 1'b1;
        ifc.wr_addr_i     = 2'd1;
        ifc.wr_data_i     = 8'h03;
        ifc.instr_valid_i = 1'b1;
        ifc.instr_i       = 8'h42;
        #1;
        chk("coll_ready", 32'(ifc.instr_ready_o), 32'd0);
        @(negedge clk);
        ifc.wr_en_i = 1'b0;
        chk("coll_not_busy", 32'(ifc.busy_o), 32'd0);
        issue_wait(8'h42, lat);
        chk("coll_latency", 32'(lat), 32'd2);
        chk("coll_result",  32'(ifc.result_o), 32'h08);
        @(negedge clk);

        // Async reset in ISSUE abandons the instruction
        preload(2'd0, 8'h05);
        preload(2'd1, 8'h02);
        @(negedge clk);
        ifc.instr_valid_i = 1'b1;
        ifc.instr_i       = 8'h42;
        @(negedge clk);
        ifc.instr_valid_i = 1'b0;
        chk("ar_busy_pre",  32'(ifc.busy_o),   32'd1);
        chk("ar_alu_rs_pre", 32'(ifc.alu_rs_o), 32'h05);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy",   32'(ifc.busy_o),       32'd0);
        chk("ar_alu_rs", 32'(ifc.alu_rs_o),     32'd0);
        chk("ar_alu_op", 32'(ifc.alu_opcode_o), 32'd0);
        chk("ar_done",   32'(ifc.done_o),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (ifc.done_o) saw_done = 1'b1;
        end
        chk("ar_no_done", 32'(saw_done), 32'd0);
        chk("ar_result",  32'(ifc.result_o), 32'd0);
        chk("ar_ready",   32'(ifc.instr_ready_o), 32'd1);
        read_reg(2'd0, rv);
        chk("ar_r0", 32'(rv), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
